// File: rtl/ast_dma_pkg.sv
// Shared types and defaults for the AST DMA command queue.
// The optional sticky overflow flag is enabled with the AST_CMDQ_OVERFLOW_EN macro.
package ast_dma_pkg;

    localparam int         DMA_DW_DEFAULT = 14;
    localparam logic [2:0] DMA_GO_SEL     = 3'd7;

    typedef struct packed {
        logic [2:0]                select;
        logic [DMA_DW_DEFAULT-1:0] data;
    } dma_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_BUSY = 2'd1,
        ST_WAIT_DONE = 2'd2
    } dma_state_e;

endpackage

// File: rtl/ast_sync_fifo.sv
// Single-clock FIFO with registered full/empty/level flags.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module ast_sync_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             push_ok, pop_ok;

    always_comb begin
        pop_ok   = pop && !empty_q;
        push_ok  = push && (!full_q || pop_ok);
        wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        level_d  = level_q + LW'(push_ok) - LW'(pop_ok);
        full_d   = (level_d == LW'(DEPTH));
        empty_d  = (level_d == '0);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // NOTE: storage is not reset; entries are only read after being written, and this keeps it a plain RAM.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;
    assign level = level_q;

endmodule

// File: rtl/ast_dma_cmd_queue.sv
// GPP-to-DMA command queue: buffers register writes and holds off issue while a launched transfer runs.
// Define AST_CMDQ_OVERFLOW_EN to build the sticky overflow flag; otherwise overflow is tied low.
module ast_dma_cmd_queue
    import ast_dma_pkg::*;
#(
    parameter int         DATAWIDTH    = DMA_DW_DEFAULT,
    parameter int         DEPTH        = 8,
    parameter logic [2:0] GO_SEL       = DMA_GO_SEL,
    parameter int         BUSY_TIMEOUT = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   gpp_write,
    input  logic [2:0]             gpp_select,
    input  logic [DATAWIDTH-1:0]   gpp_data,
    input  logic                   dma_busy,
    output logic                   dma_write,
    output logic [2:0]             dma_select,
    output logic [DATAWIDTH-1:0]   dma_data,
    output logic                   full,
    output logic                   empty,
    output logic                   pause_req,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow
);

    localparam int CW = DATAWIDTH + 3;
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);

    logic [CW-1:0]        head;
    logic [2:0]           head_sel;
    logic [DATAWIDTH-1:0] head_data;
    logic                 fifo_full, fifo_empty;
    logic                 pop;

    dma_state_e           state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic                 dma_write_q, dma_write_d;
    logic [2:0]           dma_select_q, dma_select_d;
    logic [DATAWIDTH-1:0] dma_data_q, dma_data_d;

    ast_sync_fifo #(
        .WIDTH (CW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (gpp_write),
        .pop   (pop),
        .wdata ({gpp_select, gpp_data}),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    assign {head_sel, head_data} = head;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_d      = state_q;
        timer_d      = timer_q;
        pop          = 1'b0;
        dma_write_d  = 1'b0;
        dma_select_d = dma_select_q;
        dma_data_d   = dma_data_q;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && !dma_busy) begin
                    pop          = 1'b1;
                    dma_write_d  = 1'b1;
                    dma_select_d = head_sel;
                    dma_data_d   = head_data;
                    if (head_sel == GO_SEL) begin
                        state_d = ST_WAIT_BUSY;
                        timer_d = '0;
                    end
                end
            end
            ST_WAIT_BUSY: begin
                // A launch the DMA never acknowledges must not stall the queue forever.
                if (dma_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (timer_q == TW'(BUSY_TIMEOUT - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (!dma_busy) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            dma_write_q  <= 1'b0;
            dma_select_q <= '0;
            dma_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            dma_write_q  <= dma_write_d;
            dma_select_q <= dma_select_d;
            dma_data_q   <= dma_data_d;
        end
    end

    assign dma_write  = dma_write_q;
    assign dma_select = dma_select_q;
    assign dma_data   = dma_data_q;
    assign full       = fifo_full;
    assign empty      = fifo_empty;
    assign pause_req  = fifo_full;

`ifdef AST_CMDQ_OVERFLOW_EN
    logic overflow_q, overflow_d;

    always_comb begin
        overflow_d = overflow_q | (gpp_write & fifo_full & ~pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_ast_dma_cmd_queue.sv
// Self-checking bench for ast_dma_cmd_queue: directed scenarios plus randomized traffic against a queue model.
module tb_ast_dma_cmd_queue;
    import ast_dma_pkg::*;

    localparam int         DW    = 14;
    localparam int         DEPTH = 8;
    localparam int         TO    = 4;
    localparam int         LW    = $clog2(DEPTH) + 1;
    localparam logic [2:0] GO    = 3'd7;
`ifdef AST_CMDQ_OVERFLOW_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic          clk;
    logic          reset;
    logic          gpp_write;
    logic [2:0]    gpp_select;
    logic [DW-1:0] gpp_data;
    logic          dma_busy;
    logic          dma_write;
    logic [2:0]    dma_select;
    logic [DW-1:0] dma_data;
    logic          full, empty, pause_req, overflow;
    logic [LW-1:0] level;

    int tests_run    = 0;
    int tests_failed = 0;

    ast_dma_cmd_queue #(
        .DATAWIDTH    (DW),
        .DEPTH        (DEPTH),
        .GO_SEL       (GO),
        .BUSY_TIMEOUT (TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .gpp_write  (gpp_write),
        .gpp_select (gpp_select),
        .gpp_data   (gpp_data),
        .dma_busy   (dma_busy),
        .dma_write  (dma_write),
        .dma_select (dma_select),
        .dma_data   (dma_data),
        .full       (full),
        .empty      (empty),
        .pause_req  (pause_req),
        .level      (level),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a queue of commands plus a "may issue" mode derived from the launch rules.
    dma_cmd_t      mq[$];
    int            m_mode;      // 0 free to issue, 1 launched and waiting for busy, 2 DMA busy
    int            m_waited;
    logic          exp_write;
    logic [2:0]    exp_sel;
    logic [DW-1:0] exp_data;
    logic          exp_drop;

    initial begin
        m_mode    = 0;
        m_waited  = 0;
        exp_write = 1'b0;
        exp_sel   = '0;
        exp_data  = '0;
        exp_drop  = 1'b0;
    end

    always @(posedge clk) begin : model
        int       sz;
        bit       do_pop, do_push;
        dma_cmd_t c;
        if (reset) begin
            mq.delete();
            m_mode    = 0;
            m_waited  = 0;
            exp_write = 1'b0;
            exp_sel   = '0;
            exp_data  = '0;
            exp_drop  = 1'b0;
        end else begin
            sz        = mq.size();
            do_pop    = (m_mode == 0) && (sz > 0) && !dma_busy;
            do_push   = gpp_write && ((sz < DEPTH) || do_pop);
            exp_write = 1'b0;
            if (do_pop) begin
                c         = mq.pop_front();
                exp_write = 1'b1;
                exp_sel   = c.select;
                exp_data  = c.data;
                if (c.select == GO) begin
                    m_mode   = 1;
                    m_waited = 0;
                end
            end else if (m_mode == 1) begin
                if (dma_busy) begin
                    m_mode = 2;
                end else begin
                    m_waited++;
                    if (m_waited == TO) m_mode = 0;
                end
            end else if (m_mode == 2) begin
                if (!dma_busy) m_mode = 0;
            end
            if (do_push) begin
                c.select = gpp_select;
                c.data   = gpp_data;
                mq.push_back(c);
            end else if (gpp_write) begin
                exp_drop = 1'b1;
            end
        end
    end

    task automatic drive(input logic w, input logic [2:0] s, input logic [DW-1:0] d, input logic b);
        gpp_write  = w;
        gpp_select = s;
        gpp_data   = d;
        dma_busy   = b;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b1, 3'd5, 14'h123, 1'b0);
        repeat (3) @(negedge clk);
        tests_run++;
        if ({dma_write, dma_select, dma_data, level, empty, full, pause_req, overflow} !==
            {1'b0, 3'd0, 14'h0, LW'(0), 1'b1, 1'b0, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_state: got wr=%b sel=%0d data=%h lvl=%0d e=%b f=%b p=%b ovf=%b, want all 0 except empty=1",
                     dma_write, dma_select, dma_data, level, empty, full, pause_req, overflow);
        end
        reset = 1'b0;
        drive(1'b0, 3'd0, '0, 1'b0);
        @(negedge clk);
        tests_run++;
        if ({level, empty, dma_write} !== {LW'(0), 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_write_ignored: got lvl=%0d empty=%b wr=%b, want 0 1 0", level, empty, dma_write);
        end
    endtask

    task automatic test_latency();
        @(negedge clk);
        drive(1'b1, 3'd1, 14'h0A5, 1'b0);
        @(negedge clk);
        drive(1'b0, 3'd0, '0, 1'b0);
        tests_run++;
        if ({dma_write, level, empty} !== {1'b0, LW'(1), 1'b0}) begin
            tests_failed++;
            $display("FAIL latency_push: got wr=%b lvl=%0d empty=%b, want 0 1 0", dma_write, level, empty);
        end
        @(negedge clk);
        tests_run++;
        if ({dma_write, dma_select, dma_data, level, empty} !== {1'b1, 3'd1, 14'h0A5, LW'(0), 1'b1}) begin
            tests_failed++;
            $display("FAIL latency_issue: got wr=%b sel=%0d data=%h lvl=%0d empty=%b, want 1 1 0a5 0 1",
                     dma_write, dma_select, dma_data, level, empty);
        end
        @(negedge clk);
        tests_run++;
        if ({dma_write, dma_select, dma_data} !== {1'b0, 3'd1, 14'h0A5}) begin
            tests_failed++;
            $display("FAIL latency_hold: got wr=%b sel=%0d data=%h, want 0 1 0a5", dma_write, dma_select, dma_data);
        end
    endtask

    task automatic test_launch_sequence();
        logic [2:0]    seq [4];
        logic [DW-1:0] dat [4];
        int            exp_cyc [4];
        int            got_cyc[$];
        logic [2:0]    got_sel[$];
        logic [DW-1:0] got_dat[$];
        seq     = '{3'd1, 3'd2, GO, 3'd3};
        exp_cyc = '{1, 2, 3, 26};
        foreach (dat[i]) dat[i] = DW'($urandom);
        for (int k = 0; k <= 32; k++) begin
            @(negedge clk);
            if (k > 0 && dma_write === 1'b1) begin
                got_cyc.push_back(k - 1);
                got_sel.push_back(dma_select);
                got_dat.push_back(dma_data);
            end
            if (k < 4) drive(1'b1, seq[k], dat[k], 1'b0);
            else       drive(1'b0, 3'd0, '0, (k >= 5 && k <= 24));
        end
        tests_run++;
        if (got_cyc.size() != 4) begin
            tests_failed++;
            $display("FAIL launch_count: got %0d issues, want 4", got_cyc.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests_run++;
                if (got_cyc[i] != exp_cyc[i] || got_sel[i] !== seq[i] || got_dat[i] !== dat[i]) begin
                    tests_failed++;
                    $display("FAIL launch_issue[%0d]: got cyc=%0d sel=%0d data=%h, want cyc=%0d sel=%0d data=%h",
                             i, got_cyc[i], got_sel[i], got_dat[i], exp_cyc[i], seq[i], dat[i]);
                end
            end
        end
    endtask

    task automatic test_timeout();
        logic [2:0]    seq [2];
        logic [DW-1:0] dat [2];
        int            exp_cyc [2];
        int            got_cyc[$];
        logic [2:0]    got_sel[$];
        logic [DW-1:0] got_dat[$];
        seq     = '{GO, 3'd2};
        exp_cyc = '{1, 6};
        foreach (dat[i]) dat[i] = DW'($urandom);
        for (int k = 0; k <= 12; k++) begin
            @(negedge clk);
            if (k > 0 && dma_write === 1'b1) begin
                got_cyc.push_back(k - 1);
                got_sel.push_back(dma_select);
                got_dat.push_back(dma_data);
            end
            if (k < 2) drive(1'b1, seq[k], dat[k], 1'b0);
            else       drive(1'b0, 3'd0, '0, 1'b0);
        end
        tests_run++;
        if (got_cyc.size() != 2) begin
            tests_failed++;
            $display("FAIL timeout_count: got %0d issues, want 2", got_cyc.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                tests_run++;
                if (got_cyc[i] != exp_cyc[i] || got_sel[i] !== seq[i] || got_dat[i] !== dat[i]) begin
                    tests_failed++;
                    $display("FAIL timeout_issue[%0d]: got cyc=%0d sel=%0d data=%h, want cyc=%0d sel=%0d data=%h",
                             i, got_cyc[i], got_sel[i], got_dat[i], exp_cyc[i], seq[i], dat[i]);
                end
            end
        end
    endtask

    task automatic test_fill_overflow();
        logic [2:0]    s [9];
        logic [DW-1:0] d [9];
        logic [2:0]    got_sel[$];
        logic [DW-1:0] got_dat[$];
        foreach (s[i]) begin
            s[i] = 3'($urandom_range(0, 6));
            d[i] = DW'($urandom);
        end
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (i == 8) begin
                tests_run++;
                if ({full, level, overflow} !== {1'b1, LW'(DEPTH), 1'b0}) begin
                    tests_failed++;
                    $display("FAIL fill_eight: got full=%b lvl=%0d ovf=%b, want 1 8 0", full, level, overflow);
                end
            end
            drive(1'b1, s[i], d[i], 1'b1);
        end
        @(negedge clk);
        drive(1'b0, 3'd0, '0, 1'b1);
        tests_run++;
        if ({full, pause_req, level, overflow, dma_write} !== {1'b1, 1'b1, LW'(DEPTH), OVF_EN, 1'b0}) begin
            tests_failed++;
            $display("FAIL fill_ninth_dropped: got full=%b pause=%b lvl=%0d ovf=%b wr=%b, want 1 1 8 %b 0",
                     full, pause_req, level, overflow, dma_write, OVF_EN);
        end
        for (int k = 0; k <= 12; k++) begin
            @(negedge clk);
            if (k > 0 && dma_write === 1'b1) begin
                got_sel.push_back(dma_select);
                got_dat.push_back(dma_data);
            end
            drive(1'b0, 3'd0, '0, 1'b0);
        end
        tests_run++;
        if (got_sel.size() != DEPTH) begin
            tests_failed++;
            $display("FAIL fill_drain_count: got %0d issues, want %0d", got_sel.size(), DEPTH);
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                tests_run++;
                if (got_sel[i] !== s[i] || got_dat[i] !== d[i]) begin
                    tests_failed++;
                    $display("FAIL fill_drain[%0d]: got sel=%0d data=%h, want sel=%0d data=%h",
                             i, got_sel[i], got_dat[i], s[i], d[i]);
                end
            end
        end
        tests_run++;
        if ({empty, level, overflow} !== {1'b1, LW'(0), OVF_EN}) begin
            tests_failed++;
            $display("FAIL fill_after_drain: got empty=%b lvl=%0d ovf=%b, want 1 0 %b", empty, level, overflow, OVF_EN);
        end
    endtask

    task automatic test_full_push_pop();
        logic [2:0]    s [9];
        logic [DW-1:0] d [9];
        logic [2:0]    got_sel[$];
        logic [DW-1:0] got_dat[$];
        foreach (s[i]) begin
            s[i] = 3'($urandom_range(0, 6));
            d[i] = DW'($urandom);
        end
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            drive(1'b1, s[i], d[i], 1'b1);
        end
        @(negedge clk);
        tests_run++;
        if ({full, level} !== {1'b1, LW'(DEPTH)}) begin
            tests_failed++;
            $display("FAIL pushpop_full: got full=%b lvl=%0d, want 1 8", full, level);
        end
        drive(1'b1, s[8], d[8], 1'b0);
        for (int k = 0; k <= 13; k++) begin
            @(negedge clk);
            if (k == 0) begin
                tests_run++;
                if ({full, level, dma_write} !== {1'b1, LW'(DEPTH), 1'b1}) begin
                    tests_failed++;
                    $display("FAIL pushpop_level: got full=%b lvl=%0d wr=%b, want 1 8 1", full, level, dma_write);
                end
            end
            if (dma_write === 1'b1) begin
                got_sel.push_back(dma_select);
                got_dat.push_back(dma_data);
            end
            drive(1'b0, 3'd0, '0, 1'b0);
        end
        tests_run++;
        if (got_sel.size() != 9) begin
            tests_failed++;
            $display("FAIL pushpop_count: got %0d issues, want 9", got_sel.size());
        end else begin
            for (int i = 0; i < 9; i++) begin
                tests_run++;
                if (got_sel[i] !== s[i] || got_dat[i] !== d[i]) begin
                    tests_failed++;
                    $display("FAIL pushpop_order[%0d]: got sel=%0d data=%h, want sel=%0d data=%h",
                             i, got_sel[i], got_dat[i], s[i], d[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] dz;
        dz = DW'($urandom);
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            if (k == 0)     drive(1'b1, GO, DW'($urandom), 1'b0);
            else if (k < 6) drive(1'b1, 3'($urandom_range(0, 6)), DW'($urandom), (k >= 2));
            else            drive(1'b0, 3'd0, '0, 1'b1);
        end
        @(negedge clk);
        tests_run++;
        if ({level, empty, dma_write} !== {LW'(5), 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL midreset_setup: got lvl=%0d empty=%b wr=%b, want 5 0 0", level, empty, dma_write);
        end
        reset = 1'b1;
        drive(1'b1, 3'd3, DW'($urandom), 1'b1);
        @(negedge clk);
        reset = 1'b0;
        tests_run++;
        if ({level, empty, full, dma_write, dma_select, dma_data, overflow} !==
            {LW'(0), 1'b1, 1'b0, 1'b0, 3'd0, 14'h0, 1'b0}) begin
            tests_failed++;
            $display("FAIL midreset_clear: got lvl=%0d empty=%b full=%b wr=%b sel=%0d data=%h ovf=%b, want 0 1 0 0 0 0 0",
                     level, empty, full, dma_write, dma_select, dma_data, overflow);
        end
        drive(1'b1, 3'd4, dz, 1'b1);
        @(negedge clk);
        drive(1'b0, 3'd0, '0, 1'b0);
        @(negedge clk);
        tests_run++;
        if ({dma_write, dma_select, dma_data} !== {1'b1, 3'd4, dz}) begin
            tests_failed++;
            $display("FAIL midreset_idle: got wr=%b sel=%0d data=%h, want 1 4 %h", dma_write, dma_select, dma_data, dz);
        end
    endtask

    task automatic test_random();
        logic          busy_r;
        int            shown;
        int            sz;
        logic [LW-1:0] el;
        logic          ef, ee, eo;
        busy_r = 1'b0;
        shown  = 0;
        reset  = 1'b1;
        drive(1'b0, 3'd0, '0, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            sz = mq.size();
            el = LW'(sz);
            ef = (sz == DEPTH);
            ee = (sz == 0);
            eo = OVF_EN & exp_drop;
            tests_run++;
            if ({dma_write, dma_select, dma_data, level, full, empty, pause_req, overflow} !==
                {exp_write, exp_sel, exp_data, el, ef, ee, ef, eo}) begin
                tests_failed++;
                if (shown < 10) begin
                    $display("FAIL random_cycle %0d: got wr=%b sel=%0d data=%h lvl=%0d f=%b e=%b p=%b ovf=%b, want %b %0d %h %0d %b %b %b %b",
                             c, dma_write, dma_select, dma_data, level, full, empty, pause_req, overflow,
                             exp_write, exp_sel, exp_data, el, ef, ee, ef, eo);
                end
                shown++;
            end
            reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 5) == 0) busy_r = ~busy_r;
            drive($urandom_range(0, 9) < 6, 3'($urandom_range(0, 7)), DW'($urandom), busy_r);
        end
        reset = 1'b0;
        drive(1'b0, 3'd0, '0, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 3'd0, '0, 1'b0);
        test_reset();
        test_latency();
        test_launch_sequence();
        test_timeout();
        test_fill_overflow();
        test_full_push_pop();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
